// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle for rr_mux_arbiter: per-channel input requests and a single output stream.
// The slave modport is the arbiter's view; the master modport belongs to whoever drives producers and consumer.
interface rr_mux_arbiter_if #(
    parameter int WIDTH = 2,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic                  mode;
    logic [SELW-1:0]       sel;
    logic [NCH*WIDTH-1:0]  in_data;
    logic [NCH-1:0]        in_valid;
    logic [NCH-1:0]        in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SELW-1:0]       out_ch;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// N-channel valid/ready multiplexer with fixed or round-robin selection and a single
// full-throughput registered output stage.
module rr_mux_arbiter #(
    parameter int WIDTH = 2,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    rr_mux_arbiter_if.slave    bus
);
    logic [WIDTH-1:0] ch_data [NCH];
    logic [WIDTH-1:0] out_data_reg;
    logic [SELW-1:0]  out_ch_reg;
    logic             out_valid_reg;
    logic [SELW-1:0]  ptr_reg;
    logic             load_en;
    logic             grant_any;
    logic [SELW-1:0]  grant_idx;
    int               idx;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign ch_data[gi]      = bus.in_data[gi*WIDTH +: WIDTH];
            // Reset gates the accepts directly so no producer sees a handshake while rst is high.
            assign bus.in_ready[gi] = !rst && load_en && grant_any && (grant_idx == SELW'(gi));
        end
    endgenerate

    assign load_en = !out_valid_reg || bus.out_ready;

    // Round-robin scan runs from the farthest offset down to ptr+1 so the nearest
    // requester after the last winner is the one left standing.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!bus.mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end else begin
            for (int k = NCH; k >= 1; k--) begin
                idx = int'(ptr_reg) + k;
                if (idx >= NCH) idx = idx - NCH;
                for (int i = 0; i < NCH; i++) begin
                    if (i == idx && bus.in_valid[i]) begin
                        grant_any = 1'b1;
                        grant_idx = SELW'(i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            ptr_reg       <= SELW'(NCH - 1);
        end else if (load_en) begin
            if (grant_any) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= ch_data[grant_idx];
                out_ch_reg    <= grant_idx;
                ptr_reg       <= grant_idx;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: vector table, randomized run against a
// reference model, and hand sequences for a 3-channel instance including mid-operation reset.
module tb_rr_mux_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.WIDTH(2), .NCH(4), .SELW(2)) bus4 ();
    rr_mux_arbiter_if #(.WIDTH(2), .NCH(3), .SELW(2)) bus3 ();

    rr_mux_arbiter #(.WIDTH(2), .NCH(4), .SELW(2)) u4 (.clk(clk), .rst(rst), .bus(bus4));
    rr_mux_arbiter #(.WIDTH(2), .NCH(3), .SELW(2)) u3 (.clk(clk), .rst(rst), .bus(bus3));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ready;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_ch;
        logic [1:0] exp_d;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference grant: fixed index when in range and requesting, otherwise the first
    // requester at distance 1..4 after the last winner.
    function automatic int pick(input logic mode, input int sel, input logic [3:0] v, input int last);
        int c;
        if (!mode) return (sel < 4 && ((v >> sel) & 4'd1) != 4'd0) ? sel : -1;
        for (int d = 1; d <= 4; d++) begin
            c = (last + d) % 4;
            if (((v >> c) & 4'd1) != 4'd0) return c;
        end
        return -1;
    endfunction

    task automatic u3_step(input logic [1:0] s, input logic r, input logic [2:0] erdy,
                           input logic eov, input logic [1:0] ech, input logic [1:0] ed);
        bus3.sel = s;
        bus3.out_ready = r;
        @(negedge clk);
        chk("u3_in_ready", 32'(bus3.in_ready), 32'(erdy));
        @(posedge clk);
        #1;
        chk("u3_out_valid", 32'(bus3.out_valid), 32'(eov));
        chk("u3_out_ch", 32'(bus3.out_ch), 32'(ech));
        chk("u3_out_data", 32'(bus3.out_data), 32'(ed));
        $display("u3 sel=%0d ready=%0b -> in_ready=%b out_valid=%0b out_ch=%0d out_data=%0d",
                 s, r, bus3.in_ready, bus3.out_valid, bus3.out_ch, bus3.out_data);
    endtask

    initial begin
        logic       m_valid;
        logic [1:0] m_data;
        int         m_ch, m_last, g;
        logic       load;
        logic [3:0] exp_rdy;

        for (int k = 0; k < 8; k++)
            tbl[k] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 2'(k % 4)};
        tbl[8]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
        tbl[9]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
        tbl[10] = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
        tbl[11] = '{1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
        tbl[12] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
        tbl[13] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
        tbl[14] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
        tbl[15] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd3};
        tbl[16] = '{1'b1, 2'd0, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
        tbl[17] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 2'd1};
        tbl[18] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 2'd1};
        tbl[19] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 2'd1};
        tbl[20] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
        tbl[21] = '{1'b0, 2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
        tbl[22] = '{1'b0, 2'd0, 4'hE, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd3};
        tbl[23] = '{1'b1, 2'd0, 4'h1, 1'b0, 4'b0001, 1'b1, 2'd0, 2'd0};
        tbl[24] = '{1'b1, 2'd2, 4'h5, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};

        bus4.mode = 1'b1; bus4.sel = 2'd0; bus4.in_valid = 4'hF; bus4.out_ready = 1'b1;
        bus4.in_data = 8'hE4;
        bus3.mode = 1'b0; bus3.sel = 2'd0; bus3.in_valid = 3'b000; bus3.out_ready = 1'b1;
        bus3.in_data = 6'h24;

        // Reset with every channel requesting.
        @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus4.out_data), 32'd0);
        chk("rst_out_ch", 32'(bus4.out_ch), 32'd0);
        chk("rst_in_ready", 32'(bus4.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            bus4.mode = tbl[i].mode;
            bus4.sel = tbl[i].sel;
            bus4.in_valid = tbl[i].valid;
            bus4.out_ready = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("row%0d_in_ready", i), 32'(bus4.in_ready), 32'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_out_valid", i), 32'(bus4.out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("row%0d_out_ch", i), 32'(bus4.out_ch), 32'(tbl[i].exp_ch));
            chk($sformatf("row%0d_out_data", i), 32'(bus4.out_data), 32'(tbl[i].exp_d));
            $display("row %0d mode=%0b sel=%0d valid=%b ready=%0b -> out_valid=%0b out_ch=%0d out_data=%0d",
                     i, tbl[i].mode, tbl[i].sel, tbl[i].valid, tbl[i].ready,
                     bus4.out_valid, bus4.out_ch, bus4.out_data);
        end

        // Fresh start for the randomized run so the model begins from the reset state.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_valid = 1'b0; m_data = 2'd0; m_ch = 0; m_last = 3;

        for (int n = 0; n < 200; n++) begin
            bus4.mode = 1'($urandom_range(0, 1));
            bus4.sel = 2'($urandom_range(0, 3));
            bus4.in_valid = 4'($urandom);
            bus4.in_data = 8'($urandom);
            bus4.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = pick(bus4.mode, int'(bus4.sel), bus4.in_valid, m_last);
            load = !m_valid || bus4.out_ready;
            exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
            chk("rand_in_ready", 32'(bus4.in_ready), 32'(exp_rdy));
            chk("rand_out_valid", 32'(bus4.out_valid), 32'(m_valid));
            chk("rand_out_ch", 32'(bus4.out_ch), 32'(m_ch));
            chk("rand_out_data", 32'(bus4.out_data), 32'(m_data));
            if (m_valid && bus4.out_ready)
                $display("rand %0d consumed ch=%0d data=%0d", n, bus4.out_ch, bus4.out_data);
            if (load) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_data = 2'((bus4.in_data >> (2 * g)) & 8'h3);
                    m_ch = g;
                    m_last = g;
                end else begin
                    m_valid = 1'b0;
                end
            end
            @(posedge clk);
            #1;
        end

        // Three-channel instance: out-of-range select, then reset while a word is held.
        bus3.in_valid = 3'b111;
        u3_step(2'd1, 1'b1, 3'b010, 1'b1, 2'd1, 2'd1);
        u3_step(2'd3, 1'b1, 3'b000, 1'b0, 2'd1, 2'd1);
        u3_step(2'd2, 1'b0, 3'b100, 1'b1, 2'd2, 2'd2);
        u3_step(2'd2, 1'b0, 3'b000, 1'b1, 2'd2, 2'd2);

        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus3.out_valid), 32'd0);
        chk("midrst_out_data", 32'(bus3.out_data), 32'd0);
        chk("midrst_out_ch", 32'(bus3.out_ch), 32'd0);
        chk("midrst_in_ready", 32'(bus3.in_ready), 32'd0);
        chk("midrst_u4_in_ready", 32'(bus4.in_ready), 32'd0);
        $display("mid-transfer reset: u3 out_valid=%0b in_ready=%b", bus3.out_valid, bus3.in_ready);
        @(negedge clk);
        chk("rst_hold_in_ready", 32'(bus3.in_ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
